// File: rtl/vlsu_pkg.sv
// Shared types and default sizing for the VLSU meta-info done join.
// Consumers: vmeta_done_fifo, vmeta_done_join.
package vlsu_pkg;
    localparam int VMETA_ID_W       = 3;
    localparam int VMETA_DEPTH      = 4;
    localparam int VMETA_MAX_INFLT  = 4;

    typedef logic [VMETA_ID_W-1:0] vmeta_id_t;
endpackage

// File: rtl/vmeta_done_fifo.sv
// In-order completion-id FIFO, one per side of the meta fork.
// Latency: push visible at head/empty the cycle after the handshake.
// Backpressure: push_ready_o = !full, independent of a same-cycle pop.
module vmeta_done_fifo
    import vlsu_pkg::*;
#(
    parameter int ID_W  = VMETA_ID_W,
    parameter int DEPTH = VMETA_DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_valid_i,
    output logic            push_ready_o,
    input  logic [ID_W-1:0] push_id_i,
    input  logic            pop_i,
    output logic            empty_o,
    output logic            full_o,
    output logic [ID_W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [ID_W-1:0] r_mem [DEPTH];
    logic            w_push;
    logic            w_pop;

    // Extra pointer bit separates full from empty when the index bits match.
    assign full_o       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty_o      = (r_wr_ptr == r_rd_ptr);
    assign push_ready_o = !full_o;
    assign w_push       = push_valid_i && !full_o;
    assign w_pop        = pop_i && !empty_o;
    assign head_o       = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_id_i;
    end
endmodule

// File: rtl/vmeta_done_join.sv
// Joins seq/shf completion tokens into one done token; tracks in-flight count for issue credit.
// Latency: 1 cycle from the last side's handshake to done_valid_o. Optional macro VLSU_DONE_ID_CHECK_EN adds id_err_o.
// Backpressure: done held stable while !done_ready_i; side readys drop only when their FIFO is full.
module vmeta_done_join
    import vlsu_pkg::*;
#(
    parameter int ID_W         = VMETA_ID_W,
    parameter int DEPTH        = VMETA_DEPTH,
    parameter int MAX_INFLIGHT = VMETA_MAX_INFLT
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                issue_fire_i,
    output logic                                credit_o,
    input  logic                                seq_done_valid_i,
    output logic                                seq_done_ready_o,
    input  logic [ID_W-1:0]                     seq_done_id_i,
    input  logic                                shf_done_valid_i,
    output logic                                shf_done_ready_o,
    input  logic [ID_W-1:0]                     shf_done_id_i,
    output logic                                done_valid_o,
    input  logic                                done_ready_i,
    output logic [ID_W-1:0]                     done_id_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_o
`ifdef VLSU_DONE_ID_CHECK_EN
    ,
    output logic                                id_err_o
`endif
);
    localparam int              CW      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_INFLIGHT);

    logic            w_seq_empty;
    logic            w_shf_empty;
    logic            w_seq_full;
    logic            w_shf_full;
    logic [ID_W-1:0] w_seq_head;
    logic            w_join;
    logic [CW-1:0]   r_inflight;

    assign done_valid_o = !w_seq_empty && !w_shf_empty;
    assign w_join       = done_valid_o && done_ready_i;
    assign done_id_o    = w_seq_head;

    vmeta_done_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_seq_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_valid_i (seq_done_valid_i),
        .push_ready_o (seq_done_ready_o),
        .push_id_i    (seq_done_id_i),
        .pop_i        (w_join),
        .empty_o      (w_seq_empty),
        .full_o       (w_seq_full),
        .head_o       (w_seq_head)
    );

`ifdef VLSU_DONE_ID_CHECK_EN
    logic [ID_W-1:0] w_shf_head;
    logic            r_id_err;
`endif

    vmeta_done_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_shf_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_valid_i (shf_done_valid_i),
        .push_ready_o (shf_done_ready_o),
        .push_id_i    (shf_done_id_i),
        .pop_i        (w_join),
        .empty_o      (w_shf_empty),
        .full_o       (w_shf_full),
`ifdef VLSU_DONE_ID_CHECK_EN
        .head_o       (w_shf_head)
`else
        .head_o       ()
`endif
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_inflight <= '0;
        end else begin
            case ({issue_fire_i, w_join})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign inflight_o = r_inflight;
    assign credit_o   = (r_inflight < MAX_CNT);

    // Counter never saturates; these catch the caller overrunning either end.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(issue_fire_i && !credit_o));
            assert (!(w_join && (r_inflight == '0)));
        end
    end

`ifdef VLSU_DONE_ID_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_id_err <= 1'b0;
        end else if (w_join && (w_seq_head != w_shf_head)) begin
            r_id_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && w_join) begin
            assert (w_seq_head == w_shf_head)
                else $warning("vmeta_done_join: seq/shf head id disagree on join");
        end
    end

    assign id_err_o = r_id_err;
`endif

    logic w_unused;
    assign w_unused = w_seq_full ^ w_shf_full;
endmodule

// File: tb/tb_vmeta_done_join.sv
// Directed self-checking bench for vmeta_done_join.
// Inputs change 1 time unit after posedge; outputs are sampled on the negedge.
module tb_vmeta_done_join;
    localparam int ID_W = 3;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            issue_fire;
    logic            credit;
    logic            seq_valid, seq_ready;
    logic [ID_W-1:0] seq_id;
    logic            shf_valid, shf_ready;
    logic [ID_W-1:0] shf_id;
    logic            done_valid, done_ready;
    logic [ID_W-1:0] done_id;
    logic [2:0]      inflight;
`ifdef VLSU_DONE_ID_CHECK_EN
    logic            id_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    vmeta_done_join #(.ID_W(ID_W), .DEPTH(4), .MAX_INFLIGHT(4)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .issue_fire_i     (issue_fire),
        .credit_o         (credit),
        .seq_done_valid_i (seq_valid),
        .seq_done_ready_o (seq_ready),
        .seq_done_id_i    (seq_id),
        .shf_done_valid_i (shf_valid),
        .shf_done_ready_o (shf_ready),
        .shf_done_id_i    (shf_id),
        .done_valid_o     (done_valid),
        .done_ready_i     (done_ready),
        .done_id_o        (done_id),
        .inflight_o       (inflight)
`ifdef VLSU_DONE_ID_CHECK_EN
        ,
        .id_err_o         (id_err)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        // 1: reset with side valids asserted
        rst_ni = 1'b0; issue_fire = 1'b0; done_ready = 1'b1;
        seq_valid = 1'b1; seq_id = '0; shf_valid = 1'b1; shf_id = '0;
        cyc(); smp();
        chk("rst_done_valid", done_valid, 0);
        chk("rst_credit", credit, 1);
        chk("rst_inflight", inflight, 0);
        cyc();
        rst_ni = 1'b1; seq_valid = 1'b0; shf_valid = 1'b0;
        smp();
        chk("rst_seq_ready", seq_ready, 1);
        chk("rst_shf_ready", shf_ready, 1);
        chk("rst_done_after", done_valid, 0);
        cyc();

        // 2: seq finishes at cycle 3, shf at cycle 7, done at cycle 8
        issue_fire = 1'b1; cyc(); issue_fire = 1'b0;
        smp(); chk("t2_inflight1", inflight, 1);
        cyc(); cyc();
        seq_valid = 1'b1; seq_id = 3'd0; cyc(); seq_valid = 1'b0;
        smp(); chk("t2_seq_only", done_valid, 0);
        cyc(); cyc(); cyc();
        shf_valid = 1'b1; shf_id = 3'd0; cyc(); shf_valid = 1'b0;
        smp();
        chk("t2_done_valid", done_valid, 1);
        chk("t2_done_id", done_id, 0);
        cyc(); smp();
        chk("t2_done_clear", done_valid, 0);
        chk("t2_inflight0", inflight, 0);

        // 3: four in flight, shf fills first
        done_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_fire = 1'b1; cyc();
        end
        issue_fire = 1'b0;
        smp();
        chk("t3_credit0", credit, 0);
        chk("t3_inflight4", inflight, 4);
        for (int i = 0; i < 4; i++) begin
            shf_valid = 1'b1; shf_id = 3'(i); cyc();
        end
        shf_id = 3'd5;
        smp();
        chk("t3_shf_full_rdy", shf_ready, 0);
        chk("t3_no_done", done_valid, 0);
        cyc(); shf_valid = 1'b0;
        done_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seq_valid = 1'b1; seq_id = 3'(i); cyc(); seq_valid = 1'b0;
            smp();
            chk("t3_done_valid", done_valid, 1);
            chk("t3_done_id", done_id, 32'(i));
            cyc(); smp();
            chk("t3_inflight", inflight, 32'(3 - i));
        end
        chk("t3_credit1", credit, 1);
        chk("t3_shf_ready1", shf_ready, 1);
        chk("t3_drained", done_valid, 0);
        cyc();

        // 4: backpressure holds id 2
        issue_fire = 1'b1; done_ready = 1'b0;
        seq_valid = 1'b1; seq_id = 3'd2; shf_valid = 1'b1; shf_id = 3'd2;
        cyc();
        issue_fire = 1'b0; seq_valid = 1'b0; shf_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("t4_hold_valid", done_valid, 1);
            chk("t4_hold_id", done_id, 2);
            cyc();
        end
        smp(); chk("t4_inflight_held", inflight, 1);
        done_ready = 1'b1; cyc(); smp();
        chk("t4_released", done_valid, 0);
        chk("t4_inflight0", inflight, 0);
        cyc();

        // 5: issue+join and push+pop in one cycle
        done_ready = 1'b0;
        issue_fire = 1'b1; cyc(); cyc(); issue_fire = 1'b0;
        seq_valid = 1'b1; seq_id = 3'd4; shf_valid = 1'b1; shf_id = 3'd4;
        cyc(); shf_valid = 1'b0;
        issue_fire = 1'b1; done_ready = 1'b1; seq_id = 3'd5;
        smp(); chk("t5_pre_id", done_id, 4);
        cyc();
        issue_fire = 1'b0; seq_valid = 1'b0; done_ready = 1'b0;
        smp();
        chk("t5_inflight2", inflight, 2);
        chk("t5_shf_empty", done_valid, 0);
        shf_valid = 1'b1; shf_id = 3'd5; cyc(); shf_valid = 1'b0;
        smp();
        chk("t5_seq_head5", done_id, 5);
        chk("t5_valid", done_valid, 1);
        done_ready = 1'b1; cyc(); smp();
        chk("t5_seq_one_entry", done_valid, 0);
        chk("t5_inflight1", inflight, 1);

        // 6: mismatched head ids
        done_ready = 1'b0;
        seq_valid = 1'b1; seq_id = 3'd1; shf_valid = 1'b1; shf_id = 3'd3;
        cyc(); seq_valid = 1'b0; shf_valid = 1'b0;
        smp();
        chk("t6_valid", done_valid, 1);
        chk("t6_id_seq", done_id, 1);
        done_ready = 1'b1; cyc(); smp();
        chk("t6_popped", done_valid, 0);
        chk("t6_inflight0", inflight, 0);
`ifdef VLSU_DONE_ID_CHECK_EN
        chk("t6_id_err", id_err, 1);
        cyc(); smp();
        chk("t6_id_err_sticky", id_err, 1);
`endif

        // 7: mid-operation reset drops queued tokens
        cyc();
        done_ready = 1'b0; issue_fire = 1'b1;
        seq_valid = 1'b1; seq_id = 3'd6; shf_valid = 1'b1; shf_id = 3'd6;
        cyc();
        issue_fire = 1'b0; seq_valid = 1'b0; shf_valid = 1'b0;
        smp(); chk("t7_pre_valid", done_valid, 1);
        rst_ni = 1'b0; cyc(); rst_ni = 1'b1;
        smp();
        chk("t7_rst_valid", done_valid, 0);
        chk("t7_rst_inflight", inflight, 0);
        chk("t7_rst_credit", credit, 1);
`ifdef VLSU_DONE_ID_CHECK_EN
        chk("t7_rst_id_err", id_err, 0);
`endif
        done_ready = 1'b1; cyc(); cyc(); smp();
        chk("t7_no_done", done_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
